// File: rtl/des_dec_key_schedule.sv
// DES key schedule in decryption order: emits K16..K1, one subkey per valid/ready
// handshake, by right-rotating C/D from the PC-1 image instead of storing all 16 keys.
module des_dec_key_schedule #(
  parameter bit PARITY_CHECK = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key_in,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  // Tables use FIPS numbering: entry n selects input bit n, where bit 1 is the MSB.
  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] f_pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int unsigned i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(64 - PC1_T[i])];
    end
    return r;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int unsigned i = 0; i < 48; i++) begin
      r[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
    end
    return r;
  endfunction

  // A key byte is bad when its eight bits (parity LSB included) have even parity.
  function automatic logic f_parity_bad(input logic [63:0] k);
    logic [63:0] t;
    logic        bad;
    t   = k;
    bad = 1'b0;
    for (int unsigned b = 0; b < 8; b++) begin
      bad = bad | ~(^t[7:0]);
      t   = t >> 8;
    end
    return bad;
  endfunction

  function automatic logic [27:0] f_rotr(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] r;
    case (n)
      2'd1:    r = {x[0], x[27:1]};
      2'd2:    r = {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

  state_t      r_state;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic [3:0]  r_round;
  logic        r_done;
  logic        r_parity_err;

  logic [3:0]  w_next_round;
  logic [1:0]  w_rsh;
  logic [55:0] w_pc1;

  assign w_next_round = r_round + 4'd1;
  assign w_pc1        = f_pc1(key_in);

  // Right-shift amount for the step into round w_next_round (RSH[1..15]).
  always_comb begin
    w_rsh = 2'd2;
    if (w_next_round == 4'd1 || w_next_round == 4'd8 || w_next_round == 4'd15) begin
      w_rsh = 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_c          <= '0;
      r_d          <= '0;
      r_round      <= '0;
      r_done       <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_c          <= w_pc1[55:28];
            r_d          <= w_pc1[27:0];
            r_round      <= '0;
            r_parity_err <= PARITY_CHECK ? f_parity_bad(key_in) : 1'b0;
            r_state      <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (subkey_ready) begin
            if (r_round == 4'd15) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_c     <= f_rotr(r_c, w_rsh);
              r_d     <= f_rotr(r_d, w_rsh);
              r_round <= w_next_round;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign subkey       = f_pc2({r_c, r_d});
  assign subkey_valid = (r_state == S_EMIT);
  assign busy         = (r_state == S_EMIT);
  assign round        = r_round;
  assign done         = r_done;
  assign parity_err   = r_parity_err;

endmodule
